// File: rtl/stack_pointer_unit_pkg.sv
// Shared datapath definitions for the stack pointer unit and its bus-facing helpers.
//   - BUS_WIDTH / ADDR_WIDTH : internal byte bus and stack address widths
//   - STACK_PAGE_DEFAULT     : high address byte used for stack accesses
//   - sp_state_t             : push/pull sequencer states
//   - sp_cmd_t / sp_step_t   : command bundle and modulo-256 step result
package stack_pointer_unit_pkg;

  localparam int unsigned BUS_WIDTH  = 8;
  localparam int unsigned ADDR_WIDTH = 2 * BUS_WIDTH;

  localparam logic [BUS_WIDTH-1:0] STACK_PAGE_DEFAULT = 8'h01;
  localparam logic [BUS_WIDTH-1:0] SP_RESET_DEFAULT   = 8'hFF;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PUSH_ADDR = 2'd1,
    PULL_INC  = 2'd2,
    PULL_ADDR = 2'd3
  } sp_state_t;

  // Commands sampled from the control unit in one cycle.
  typedef struct packed {
    logic load;
    logic push;
    logic pull;
    logic inc;
    logic dec;
  } sp_cmd_t;

  // Result of a +/-1 update, with the 00/FF crossing flag.
  typedef struct packed {
    logic                 wrap;
    logic [BUS_WIDTH-1:0] value;
  } sp_step_t;

  function automatic sp_step_t sp_inc(input logic [BUS_WIDTH-1:0] v);
    sp_step_t r;
    r.value = v + BUS_WIDTH'(1);
    r.wrap  = (v == '1);
    return r;
  endfunction

  function automatic sp_step_t sp_dec(input logic [BUS_WIDTH-1:0] v);
    sp_step_t r;
    r.value = v - BUS_WIDTH'(1);
    r.wrap  = (v == '0);
    return r;
  endfunction

  // Keep only the highest-priority command: load > push > pull > inc > dec.
  function automatic sp_cmd_t sp_prioritize(input sp_cmd_t raw);
    sp_cmd_t r;
    r      = '0;
    if (raw.load)      r.load = 1'b1;
    else if (raw.push) r.push = 1'b1;
    else if (raw.pull) r.pull = 1'b1;
    else if (raw.inc)  r.inc  = 1'b1;
    else if (raw.dec)  r.dec  = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/stack_pointer_unit_bus_driver.sv
// Gated byte source for one slot of the OR-combined internal bus.
// Drives value_i when drive_i is high, otherwise all zeros so the slot
// contributes nothing to the OR.
//   drive_i : select this source onto the bus
//   value_i : register value to present
//   data_o  : bus slot contribution (combinational)
module sp_bus_driver
  import stack_pointer_unit_pkg::*;
#(
  parameter int unsigned WIDTH = BUS_WIDTH
) (
  input  logic             drive_i,
  input  logic [WIDTH-1:0] value_i,
  output logic [WIDTH-1:0] data_o
);

  assign data_o = drive_i ? value_i : '0;

endmodule

// File: rtl/stack_pointer_unit.sv
// 8-bit stack pointer with push (post-decrement) and pull (pre-increment)
// sequencing, page-1 stack address generation and a gated bus source.
//   clk, nrst  : clock, synchronous active-low reset
//   busIn      : internal bus output, loaded by loadSP
//   loadSP     : SP <= busIn (also aborts a running push/pull)
//   pushReq    : start push sequence
//   pullReq    : start pull sequence
//   incSP      : SP <= SP+1 when idle
//   decSP      : SP <= SP-1 when idle
//   driveSP    : place SP on busDrive
//   busDrive   : SP or 8'h00, combinational
//   stackAddr  : {STACK_PAGE, SP}, combinational
//   addrValid  : stack address is valid this cycle
//   busy       : push/pull sequence in progress
//   wrap       : one-cycle pulse after an update crossing 00/FF
module stack_pointer_unit
  import stack_pointer_unit_pkg::*;
#(
  parameter logic [BUS_WIDTH-1:0] RESET_VALUE = SP_RESET_DEFAULT,
  parameter logic [BUS_WIDTH-1:0] STACK_PAGE  = STACK_PAGE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [BUS_WIDTH-1:0]  busIn,
  input  logic                  loadSP,
  input  logic                  pushReq,
  input  logic                  pullReq,
  input  logic                  incSP,
  input  logic                  decSP,
  input  logic                  driveSP,
  output logic [BUS_WIDTH-1:0]  busDrive,
  output logic [ADDR_WIDTH-1:0] stackAddr,
  output logic                  addrValid,
  output logic                  busy,
  output logic                  wrap
);

  sp_state_t            state_q, state_d;
  logic [BUS_WIDTH-1:0] sp_q, sp_d;
  logic                 wrap_q, wrap_d;
  sp_cmd_t              cmd_raw, cmd;
  sp_step_t             step_up, step_dn;

  assign cmd_raw = '{load: loadSP, push: pushReq, pull: pullReq, inc: incSP, dec: decSP};
  assign cmd     = sp_prioritize(cmd_raw);
  assign step_up = sp_inc(sp_q);
  assign step_dn = sp_dec(sp_q);

  // Next-state logic; a load overrides everything, including a running sequence.
  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    wrap_d  = 1'b0;
    if (cmd.load) begin
      sp_d    = busIn;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd.push) begin
            state_d = PUSH_ADDR;
          end else if (cmd.pull) begin
            state_d = PULL_INC;
          end else if (cmd.inc) begin
            sp_d   = step_up.value;
            wrap_d = step_up.wrap;
          end else if (cmd.dec) begin
            sp_d   = step_dn.value;
            wrap_d = step_dn.wrap;
          end
        end
        // Address was presented with the pre-decrement SP this cycle.
        PUSH_ADDR: begin
          sp_d    = step_dn.value;
          wrap_d  = step_dn.wrap;
          state_d = IDLE;
        end
        // Pre-increment so the following address cycle uses the new SP.
        PULL_INC: begin
          sp_d    = step_up.value;
          wrap_d  = step_up.wrap;
          state_d = PULL_ADDR;
        end
        PULL_ADDR: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      sp_q    <= RESET_VALUE;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      wrap_q  <= wrap_d;
    end
  end

  assign stackAddr = {STACK_PAGE, sp_q};
  assign addrValid = (state_q == PUSH_ADDR) || (state_q == PULL_ADDR);
  assign busy      = (state_q != IDLE);
  assign wrap      = wrap_q;

  sp_bus_driver #(
    .WIDTH (BUS_WIDTH)
  ) u_bus_driver (
    .drive_i (driveSP),
    .value_i (sp_q),
    .data_o  (busDrive)
  );

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Self-checking bench for stack_pointer_unit: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// queue-based behavioural model.
module tb_stack_pointer_unit;

  logic        clk;
  logic        nrst;
  logic [7:0]  busIn;
  logic        loadSP, pushReq, pullReq, incSP, decSP, driveSP;
  logic [7:0]  busDrive;
  logic [15:0] stackAddr;
  logic        addrValid, busy, wrap;

  int n_checks = 0;
  int n_err    = 0;

  stack_pointer_unit dut (
    .clk       (clk),
    .nrst      (nrst),
    .busIn     (busIn),
    .loadSP    (loadSP),
    .pushReq   (pushReq),
    .pullReq   (pullReq),
    .incSP     (incSP),
    .decSP     (decSP),
    .driveSP   (driveSP),
    .busDrive  (busDrive),
    .stackAddr (stackAddr),
    .addrValid (addrValid),
    .busy      (busy),
    .wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // A running push/pull is a list of remaining cycles; each cycle says whether
  // the address is shown and how SP moves at the end of that cycle.
  typedef struct {
    bit av;
    int delta;
  } step_t;

  step_t m_plan[$];
  int    m_sp    = 0;
  bit    m_wrap  = 0;
  bit    m_ready = 0;

  function automatic void m_move(input int d);
    int n;
    n      = m_sp + d;
    m_wrap = (n < 0) || (n > 255);
    m_sp   = (n + 256) % 256;
  endfunction

  always @(posedge clk) begin
    if (!nrst) begin
      m_sp    = 255;
      m_wrap  = 0;
      m_plan.delete();
      m_ready = 1;
    end else if (m_ready) begin
      if (loadSP) begin
        m_sp   = int'(busIn);
        m_wrap = 0;
        m_plan.delete();
      end else if (m_plan.size() != 0) begin
        step_t s;
        s = m_plan.pop_front();
        m_move(s.delta);
      end else if (pushReq) begin
        m_plan.push_back('{av: 1'b1, delta: -1});
        m_wrap = 0;
      end else if (pullReq) begin
        m_plan.push_back('{av: 1'b0, delta: 1});
        m_plan.push_back('{av: 1'b1, delta: 0});
        m_wrap = 0;
      end else if (incSP) begin
        m_move(1);
      end else if (decSP) begin
        m_move(-1);
      end else begin
        m_wrap = 0;
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_ready) begin
      bit   exp_av;
      logic [7:0] exp_bd;
      exp_av = (m_plan.size() != 0) && m_plan[0].av;
      exp_bd = driveSP ? 8'(m_sp) : 8'h00;
      check("m_busDrive",  16'(busDrive),  16'(exp_bd));
      check("m_stackAddr", stackAddr,      {8'h01, 8'(m_sp)});
      check("m_addrValid", 16'(addrValid), 16'(exp_av));
      check("m_busy",      16'(busy),      16'(m_plan.size() != 0));
      check("m_wrap",      16'(wrap),      16'(m_wrap));
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input bit ld, input bit ps, input bit pl,
                        input bit ic, input bit dc, input bit dv, input logic [7:0] b);
    loadSP  = ld;
    pushReq = ps;
    pullReq = pl;
    incSP   = ic;
    decSP   = dc;
    driveSP = dv;
    busIn   = b;
  endtask

  task automatic idle_in();
    set_in(0, 0, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    set_in(1, 0, 0, 0, 0, 0, v);
    tick();
    idle_in();
  endtask

  initial begin
    nrst = 1'b0;
    idle_in();

    // Reset state, busDrive gating during reset
    tick();
    tick();
    check("rst_busDrive0", 16'(busDrive), 16'h0000);
    check("rst_addrValid", 16'(addrValid), 16'h0000);
    check("rst_busy", 16'(busy), 16'h0000);
    check("rst_stackAddr", stackAddr, 16'h01FF);
    check("rst_model_sp", 16'(m_sp), 16'h00FF);
    driveSP = 1'b1;
    #1;
    check("rst_busDriveFF", 16'(busDrive), 16'h00FF);
    nrst = 1'b1;
    tick();
    idle_in();

    // Load then push: address with old SP, then decrement
    load(8'h3C);
    check("load_3C", stackAddr, 16'h013C);
    set_in(0, 1, 0, 0, 0, 0, 8'h00);
    tick();
    idle_in();
    check("push_c1_addr", stackAddr, 16'h013C);
    check("push_c1_av", 16'(addrValid), 16'h0001);
    check("push_c1_busy", 16'(busy), 16'h0001);
    tick();
    check("push_c2_sp", stackAddr, 16'h013B);
    check("push_c2_busy", 16'(busy), 16'h0000);
    check("push_model_sp", 16'(m_sp), 16'h003B);

    // Pull from FF: increment wraps to 00
    load(8'hFF);
    set_in(0, 0, 1, 0, 0, 0, 8'h00);
    tick();
    idle_in();
    check("pull_c1_busy", 16'(busy), 16'h0001);
    check("pull_c1_av", 16'(addrValid), 16'h0000);
    tick();
    check("pull_c2_addr", stackAddr, 16'h0100);
    check("pull_c2_av", 16'(addrValid), 16'h0001);
    check("pull_c2_wrap", 16'(wrap), 16'h0001);
    tick();
    check("pull_c3_wrap", 16'(wrap), 16'h0000);
    check("pull_c3_busy", 16'(busy), 16'h0000);

    // Push from 00 wraps to FF; decSP from 00 likewise
    load(8'h00);
    set_in(0, 1, 0, 0, 0, 0, 8'h00);
    tick();
    idle_in();
    check("push00_addr", stackAddr, 16'h0100);
    tick();
    check("push00_sp", stackAddr, 16'h01FF);
    check("push00_wrap", 16'(wrap), 16'h0001);
    tick();
    check("push00_wrap_off", 16'(wrap), 16'h0000);
    load(8'h00);
    check("load_no_wrap", 16'(wrap), 16'h0000);
    set_in(0, 0, 0, 0, 1, 0, 8'h00);
    tick();
    idle_in();
    check("dec00_sp", stackAddr, 16'h01FF);
    check("dec00_wrap", 16'(wrap), 16'h0001);

    // Priority: load wins over push and inc
    set_in(1, 1, 0, 1, 0, 0, 8'h80);
    tick();
    idle_in();
    check("prio_sp", stackAddr, 16'h0180);
    check("prio_busy", 16'(busy), 16'h0000);
    tick();
    check("prio_sp_hold", stackAddr, 16'h0180);
    check("prio_busy_hold", 16'(busy), 16'h0000);

    // pushReq during PULL_INC is ignored
    load(8'h10);
    set_in(0, 0, 1, 0, 0, 0, 8'h00);
    tick();
    set_in(0, 1, 0, 0, 0, 0, 8'h00);
    tick();
    idle_in();
    check("ign_push_av", 16'(addrValid), 16'h0001);
    check("ign_push_addr", stackAddr, 16'h0111);
    tick();
    check("ign_push_idle", 16'(busy), 16'h0000);
    check("ign_push_sp", stackAddr, 16'h0111);

    // loadSP during PULL_INC aborts the pull
    set_in(0, 0, 1, 0, 0, 0, 8'h00);
    tick();
    load(8'h55);
    check("abort_sp", stackAddr, 16'h0155);
    check("abort_busy", 16'(busy), 16'h0000);
    check("abort_av", 16'(addrValid), 16'h0000);
    tick();
    check("abort_av2", 16'(addrValid), 16'h0000);
    check("abort_sp2", stackAddr, 16'h0155);

    // Reset during PUSH_ADDR
    load(8'h20);
    set_in(0, 1, 0, 0, 0, 0, 8'h00);
    tick();
    idle_in();
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    check("rstmid_busy", 16'(busy), 16'h0000);
    check("rstmid_av", 16'(addrValid), 16'h0000);
    check("rstmid_sp", stackAddr, 16'h01FF);
    tick();
    check("rstmid_sp2", stackAddr, 16'h01FF);

    // Randomized traffic, biased towards wrap boundaries
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] b;
      int unsigned sel;
      sel = $urandom_range(0, 5);
      case (sel)
        0: b = 8'h00;
        1: b = 8'hFF;
        2: b = 8'h01;
        3: b = 8'hFE;
        default: b = 8'($urandom);
      endcase
      set_in(($urandom % 12) == 0, ($urandom % 5) == 0, ($urandom % 5) == 0,
             ($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 2) == 0, b);
      nrst = (($urandom % 80) != 0);
      tick();
    end

    idle_in();
    nrst = 1'b1;
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
